// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR pseudo-random generator.
// Holds the control FSM encoding and the default 64-bit tap mask.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } lfsrState_t;

  // x^64 + x^63 + x^61 + x^60 + 1 in Fibonacci tap-mask form.
  localparam logic [63:0] DEFAULT_TAPS64 = 64'hD800_0000_0000_0000;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;
  localparam int MIN_STEPS = 1;
  localparam int MAX_STEPS = 8;

endpackage : lfsr_pkg

// File: rtl/lfsr_step.sv
// One combinational LFSR step, in either Fibonacci or Galois form.
// The tap mask is always given in Fibonacci orientation.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] TAPS   = DEFAULT_TAPS64[63 -: WIDTH],
  parameter bit               GALOIS = 1'b0
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  // Galois feedback polynomial drops the x^WIDTH term and adds the constant term.
  localparam logic [WIDTH-1:0] POLY = {TAPS[WIDTH-2:0], 1'b1};

  generate
    if (GALOIS) begin : g_galois
      always_comb begin
        o_next = {i_state[WIDTH-2:0], 1'b0} ^ ({WIDTH{i_state[WIDTH-1]}} & POLY);
      end
    end else begin : g_fibonacci
      always_comb begin
        o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};
      end
    end
  endgenerate

endmodule : lfsr_step

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random generator with seed capture, lockup detection and
// period measurement; advances STEPS chained steps per enabled cycle.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] TAPS   = DEFAULT_TAPS64[63 -: WIDTH],
  parameter bit               GALOIS = 1'b0,
  parameter int               STEPS  = 1,
  parameter int               CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_load,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_out,
  output logic             o_valid,
  output logic             o_lockup,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_period
);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_badWidth
      $error("lfsr_prng: WIDTH must be within 4..64");
    end
    if (STEPS < MIN_STEPS || STEPS > MAX_STEPS) begin : g_badSteps
      $error("lfsr_prng: STEPS must be within 1..8");
    end
    if (CNT_W < 1) begin : g_badCntW
      $error("lfsr_prng: CNT_W must be at least 1");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_badTaps
      $error("lfsr_prng: TAPS must have its top bit set");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lfsrState_t       r_state;
  lfsrState_t       w_stateNext;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seedCap;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic             r_wrap;

  logic [WIDTH-1:0] w_chain [STEPS+1];
  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_countInc;
  logic             w_hit;
  logic             w_seedNonZero;
  logic             w_advance;

  // Intermediate steps are never compared against the seed; only w_next is.
  assign w_chain[0] = r_lfsr;
  generate
    for (genvar g = 0; g < STEPS; g++) begin : g_step
      lfsr_step #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
      ) u_step (
        .i_state (w_chain[g]),
        .o_next  (w_chain[g+1])
      );
    end
  endgenerate

  assign w_next        = w_chain[STEPS];
  assign w_hit         = (w_next == r_seedCap);
  assign w_seedNonZero = (i_seed != '0);
  assign w_advance     = (r_state == RUN) && i_enable && !i_load;
  assign w_countInc    = (r_count == CNT_MAX) ? CNT_MAX : r_count + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, RUN, LOCKED: begin
        if (i_load) begin
          w_stateNext = w_seedNonZero ? RUN : LOCKED;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    o_out    = (r_state == LOCKED) ? '0 : r_lfsr;
    o_valid  = (r_state == RUN);
    o_lockup = (r_state == LOCKED);
    o_wrap   = r_wrap;
    o_period = r_period;
  end

  // Load wins over enable in every state; wrap is a single-cycle pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr    <= '0;
      r_seedCap <= '0;
      r_count   <= '0;
      r_period  <= '0;
      r_wrap    <= 1'b0;
    end else if (i_load) begin
      r_lfsr    <= i_seed;
      r_seedCap <= i_seed;
      r_count   <= '0;
      r_period  <= '0;
      r_wrap    <= 1'b0;
    end else if (w_advance) begin
      r_lfsr <= w_next;
      if (w_hit) begin
        r_wrap   <= 1'b1;
        r_period <= w_countInc;
        r_count  <= '0;
      end else begin
        r_wrap  <= 1'b0;
        r_count <= w_countInc;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

endmodule : lfsr_prng

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: three 4-bit variants (Fibonacci, Galois,
// Fibonacci two-step) sharing stimulus, plus one default 64-bit instance.
module tb_lfsr_prng;

  logic        clk;
  logic        reset;
  logic        load;
  logic        enable;
  logic [3:0]  seed;
  logic [63:0] seed64;

  logic [3:0]  outFib, outGal, outFib2;
  logic        validFib, validGal, validFib2;
  logic        lockFib, lockGal, lockFib2;
  logic        wrapFib, wrapGal, wrapFib2;
  logic [7:0]  perFib, perGal, perFib2;

  logic [63:0] out64;
  logic        valid64, lock64, wrap64;
  logic [7:0]  per64;

  int nCompared;
  int nMismatched;

  logic [3:0] fibSeq  [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] galSeq  [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7,
                               4'hE, 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};
  logic [3:0] fib2Seq [16] = '{4'h1, 4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8,
                               4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};

  lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b0), .STEPS(1), .CNT_W(8)) u_fib (
    .i_clk(clk), .i_reset(reset), .i_seed(seed), .i_load(load), .i_enable(enable),
    .o_out(outFib), .o_valid(validFib), .o_lockup(lockFib), .o_wrap(wrapFib), .o_period(perFib));

  lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b1), .STEPS(1), .CNT_W(8)) u_gal (
    .i_clk(clk), .i_reset(reset), .i_seed(seed), .i_load(load), .i_enable(enable),
    .o_out(outGal), .o_valid(validGal), .o_lockup(lockGal), .o_wrap(wrapGal), .o_period(perGal));

  lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b0), .STEPS(2), .CNT_W(8)) u_fib2 (
    .i_clk(clk), .i_reset(reset), .i_seed(seed), .i_load(load), .i_enable(enable),
    .o_out(outFib2), .o_valid(validFib2), .o_lockup(lockFib2), .o_wrap(wrapFib2), .o_period(perFib2));

  lfsr_prng #(.WIDTH(64), .CNT_W(8)) u_wide (
    .i_clk(clk), .i_reset(reset), .i_seed(seed64), .i_load(load), .i_enable(enable),
    .o_out(out64), .o_valid(valid64), .o_lockup(lock64), .o_wrap(wrap64), .o_period(per64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then sample 1 time unit after the following rising edge.
  task automatic applyStimulus(input logic ld, input logic en, input logic [3:0] sd);
    load   = ld;
    enable = en;
    seed   = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nCompared++;
    if ({outFib, validFib, lockFib, wrapFib, perFib} !== 15'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_fib got %h expected 0", {outFib, validFib, lockFib, wrapFib, perFib});
    end
    nCompared++;
    if ({out64, valid64, lock64, wrap64, per64} !== 75'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_wide got %h expected 0", {out64, valid64, lock64, wrap64, per64});
    end
  endtask

  task automatic test_idle_enable();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'h7);
    nCompared++;
    if ({outFib, validFib, outGal, validGal} !== 10'h0) begin
      nMismatched++;
      $display("[TB] FAIL idle_enable got %h expected 0", {outFib, validFib, outGal, validGal});
    end
  endtask

  task automatic test_sequences();
    logic expWrap;
    applyStimulus(1'b1, 1'b0, 4'h1);
    nCompared++;
    if ({outFib, validFib, outGal, validGal, outFib2, validFib2} !== {4'h1, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL seq_load got %h expected %h", {outFib, validFib, outGal, validGal, outFib2, validFib2},
               {4'h1, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1});
    end
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b0, 1'b1, 4'h1);
      expWrap = (i == 15);
      nCompared++;
      if (outFib !== fibSeq[i]) begin
        nMismatched++;
        $display("[TB] FAIL fib_step%0d got %h expected %h", i, outFib, fibSeq[i]);
      end
      nCompared++;
      if (outGal !== galSeq[i]) begin
        nMismatched++;
        $display("[TB] FAIL gal_step%0d got %h expected %h", i, outGal, galSeq[i]);
      end
      nCompared++;
      if (outFib2 !== fib2Seq[i]) begin
        nMismatched++;
        $display("[TB] FAIL fib2_step%0d got %h expected %h", i, outFib2, fib2Seq[i]);
      end
      nCompared++;
      if ({wrapFib, wrapGal, wrapFib2} !== {3{expWrap}}) begin
        nMismatched++;
        $display("[TB] FAIL wrap_cycle%0d got %b expected %b", i, {wrapFib, wrapGal, wrapFib2}, {3{expWrap}});
      end
    end
    nCompared++;
    if ({perFib, perGal, perFib2} !== {8'd15, 8'd15, 8'd15}) begin
      nMismatched++;
      $display("[TB] FAIL period15 got %0d/%0d/%0d expected 15/15/15", perFib, perGal, perFib2);
    end
    applyStimulus(1'b0, 1'b0, 4'h1);
    nCompared++;
    if ({wrapFib, perFib, outFib, validFib} !== {1'b0, 8'd15, 4'h1, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL hold_after_wrap got %h expected %h", {wrapFib, perFib, outFib, validFib},
               {1'b0, 8'd15, 4'h1, 1'b1});
    end
  endtask

  task automatic test_lockup();
    applyStimulus(1'b1, 1'b0, 4'h0);
    nCompared++;
    if ({lockFib, validFib, outFib, perFib} !== {1'b1, 1'b0, 4'h0, 8'd0}) begin
      nMismatched++;
      $display("[TB] FAIL lock_enter got %h expected %h", {lockFib, validFib, outFib, perFib}, {1'b1, 1'b0, 4'h0, 8'd0});
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'h0);
    nCompared++;
    if ({lockFib, validFib, outFib, lockGal, outGal} !== {1'b1, 1'b0, 4'h0, 1'b1, 4'h0}) begin
      nMismatched++;
      $display("[TB] FAIL lock_hold got %h expected %h", {lockFib, validFib, outFib, lockGal, outGal},
               {1'b1, 1'b0, 4'h0, 1'b1, 4'h0});
    end
    applyStimulus(1'b1, 1'b0, 4'h5);
    nCompared++;
    if ({lockFib, validFib, outFib} !== {1'b0, 1'b1, 4'h5}) begin
      nMismatched++;
      $display("[TB] FAIL lock_exit got %h expected %h", {lockFib, validFib, outFib}, {1'b0, 1'b1, 4'h5});
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'h5);
    #2;
    reset = 1'b1;
    #1;
    nCompared++;
    if ({outFib, validFib, lockFib, wrapFib, perFib, outGal, validGal} !== 20'h0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset got %h expected 0", {outFib, validFib, lockFib, wrapFib, perFib, outGal, validGal});
    end
    @(negedge clk);
    reset  = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'h6);
    nCompared++;
    if ({outFib, validFib, outGal, validGal} !== {4'h6, 1'b1, 4'h6, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL load_wins got %h expected %h", {outFib, validFib, outGal, validGal}, {4'h6, 1'b1, 4'h6, 1'b1});
    end
    for (int i = 1; i <= 15; i++) applyStimulus(1'b0, 1'b1, 4'h6);
    nCompared++;
    if ({wrapFib, perFib, outFib, wrapGal, perGal} !== {1'b1, 8'd15, 4'h6, 1'b1, 8'd15}) begin
      nMismatched++;
      $display("[TB] FAIL count_cleared got %h expected %h", {wrapFib, perFib, outFib, wrapGal, perGal},
               {1'b1, 8'd15, 4'h6, 1'b1, 8'd15});
    end
  endtask

  task automatic test_wide_long();
    int badValid;
    int badWrap;
    badValid = 0;
    badWrap  = 0;
    seed64 = 64'h0040_4040_0000_0600;
    applyStimulus(1'b1, 1'b0, 4'h1);
    nCompared++;
    if ({out64, valid64} !== {64'h0040_4040_0000_0600, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL wide_load got %h expected %h", {out64, valid64}, {64'h0040_4040_0000_0600, 1'b1});
    end
    applyStimulus(1'b0, 1'b1, 4'h1);
    nCompared++;
    if (out64 !== 64'h0080_8080_0000_0C00) begin
      nMismatched++;
      $display("[TB] FAIL wide_step1 got %h expected %h", out64, 64'h0080_8080_0000_0C00);
    end
    for (int i = 1; i < 65536; i++) begin
      applyStimulus(1'b0, 1'b1, 4'h1);
      if (valid64 !== 1'b1) badValid++;
      if (wrap64 !== 1'b0) badWrap++;
    end
    nCompared++;
    if (badValid !== 0) begin
      nMismatched++;
      $display("[TB] FAIL wide_valid got %0d bad cycles expected 0", badValid);
    end
    nCompared++;
    if (badWrap !== 0) begin
      nMismatched++;
      $display("[TB] FAIL wide_nowrap got %0d wrap cycles expected 0", badWrap);
    end
    nCompared++;
    if ({per64, lock64} !== 9'h0) begin
      nMismatched++;
      $display("[TB] FAIL wide_period got %h expected 0", {per64, lock64});
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset  = 1'b1;
    load   = 1'b0;
    enable = 1'b0;
    seed   = 4'h0;
    seed64 = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_idle_enable();
    test_sequences();
    test_lockup();
    test_reset_mid_run();
    test_wide_long();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_lfsr_prng
